// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO sequencer: command encodings, FSM states,
// default sizing and a small command-decode helper.
package hilo_pkg;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        OP_DIVU = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b10,
        ST_FIX    = 2'b11
    } state_e;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_if.sv
// Command, status and divider-side signals of the HI/LO sequencer.
// The slave modport is the sequencer; master is the control unit plus divider.
interface hilo_if
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();
    logic             op_start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_start;
    logic             div_end_in;
    logic [WIDTH-1:0] div_hi_in;
    logic [WIDTH-1:0] div_lo_in;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0_exc;
    logic             timeout_err;

    modport master (
        output op_start, op, rs_val, rt_val, div_end_in, div_hi_in, div_lo_in,
        input  div_a, div_b, div_start, hi, lo, busy, done, div0_exc, timeout_err
    );

    modport slave (
        input  op_start, op, rs_val, rt_val, div_end_in, div_hi_in, div_lo_in,
        output div_a, div_b, div_start, hi, lo, busy, done, div0_exc, timeout_err
    );
endinterface

// File: rtl/hilo_sign_fix.sv
// Combinational sign handling around the unsigned divider: operand magnitudes
// and sign flags on the way in, conditional negation of quotient/remainder out.
module hilo_sign_fix
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             signed_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             qneg,
    input  logic             rneg,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] rem_in,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             qneg_out,
    output logic             rneg_out,
    output logic [WIDTH-1:0] quo_out,
    output logic [WIDTH-1:0] rem_out
);
    logic rs_neg_s;
    logic rt_neg_s;

    assign rs_neg_s = signed_op & rs_val[WIDTH-1];
    assign rt_neg_s = signed_op & rt_val[WIDTH-1];

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign a_mag    = rs_neg_s ? -rs_val : rs_val;
    assign b_mag    = rt_neg_s ? -rt_val : rt_val;
    assign qneg_out = rs_neg_s ^ rt_neg_s;
    assign rneg_out = rs_neg_s;

    assign quo_out  = qneg ? -quo_in : quo_in;
    assign rem_out  = rneg ? -rem_in : rem_in;

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: runs MTHI/MTLO in one cycle, launches and supervises the
// iterative divider for DIV/DIVU, and applies sign correction on completion.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic  clock,
    input  logic  reset,
    hilo_if.slave bus
);
    localparam int                 WDOG_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]  div_a_q, div_a_d, div_b_q, div_b_d;
    logic              div_start_q, div_start_d, busy_q, busy_d;
    logic              done_q, done_d, div0_q, div0_d, tmo_q, tmo_d;

    logic [WIDTH-1:0]  a_mag_s, b_mag_s, lo_fix_s, hi_fix_s;
    logic              qneg_s, rneg_s, rt_zero_s, launch_s, wait_end_s;

    hilo_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .signed_op (bus.op == OP_DIV),
        .rs_val    (bus.rs_val),
        .rt_val    (bus.rt_val),
        .qneg      (qneg_q),
        .rneg      (rneg_q),
        .quo_in    (bus.div_lo_in),
        .rem_in    (bus.div_hi_in),
        .a_mag     (a_mag_s),
        .b_mag     (b_mag_s),
        .qneg_out  (qneg_s),
        .rneg_out  (rneg_s),
        .quo_out   (lo_fix_s),
        .rem_out   (hi_fix_s)
    );

    assign rt_zero_s  = (bus.rt_val == '0);
    assign launch_s   = (state_q == ST_IDLE) && bus.op_start && is_div_op(bus.op) && !rt_zero_s;
    // wdog is still zero only in the first WAIT cycle, where div_end_in is a stale level.
    assign wait_end_s = (wdog_q != '0) && bus.div_end_in;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = launch_s ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_end_s) begin
                    state_d = ST_FIX;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FIX:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath and status next values.
    always_comb begin
        hi_d        = hi_q;
        lo_d        = lo_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        wdog_d      = wdog_q;
        div_start_d = 1'b0;
        done_d      = 1'b0;
        div0_d      = 1'b0;
        tmo_d       = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (bus.op_start) begin
                    case (bus.op)
                        OP_MTHI: begin
                            hi_d   = bus.rs_val;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.rs_val;
                            done_d = 1'b1;
                        end
                        default: begin
                            if (rt_zero_s) begin
                                div0_d = 1'b1;
                            end else begin
                                div_a_d     = a_mag_s;
                                div_b_d     = b_mag_s;
                                qneg_d      = qneg_s;
                                rneg_d      = rneg_s;
                                div_start_d = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    div_start_d = 1'b0;
                end
            end
            ST_LAUNCH: wdog_d = '0;
            ST_WAIT: begin
                if (wait_end_s) begin
                    wdog_d = wdog_q;
                end else if (wdog_q == WDOG_LAST) begin
                    tmo_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            ST_FIX: begin
                hi_d   = hi_fix_s;
                lo_d   = lo_fix_s;
                done_d = 1'b1;
            end
            default: wdog_d = '0;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_q        <= '0;
            lo_q        <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            wdog_q      <= '0;
            div_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div0_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            wdog_q      <= wdog_d;
            div_start_q <= div_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div0_q      <= div0_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_a       = div_a_q;
    assign bus.div_b       = div_b_q;
    assign bus.div_start   = div_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div0_exc    = div0_q;
    assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: fixed vector table, hand-written corner sequences and
// random commands against a behavioural divider and an arithmetic HI/LO model.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int K_DONE = 0;
    localparam int K_DIV0 = 1;
    localparam int K_TMO  = 2;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          kind;
        int          lat;
        int          starts;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clock;
    logic reset;
    logic div_hang;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_hi, exp_lo;

    hilo_if #(.WIDTH(32)) bus ();

    hilo_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(40)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural divider: end flag rises 33 edges after start is seen, with the
    // previous op's end level left high through the first WAIT cycle.
    int          pend;
    logic [31:0] a_cap, b_cap;
    always @(posedge clock) begin
        #1;
        if (reset) begin
            pend = 0;
            bus.div_end_in = 1'b0;
            bus.div_hi_in  = 32'h0;
            bus.div_lo_in  = 32'h0;
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 31) bus.div_end_in = 1'b0;
            if (pend == 0 && !div_hang) begin
                bus.div_end_in = 1'b1;
                bus.div_lo_in  = (b_cap == 32'h0) ? 32'hFFFF_FFFF : a_cap / b_cap;
                bus.div_hi_in  = (b_cap == 32'h0) ? a_cap : a_cap % b_cap;
            end
        end else if (bus.div_start) begin
            pend  = 33;
            a_cap = bus.div_a;
            b_cap = bus.div_b;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one command and follow it to its completion pulse (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit poke, output int kind, output int lat, output int starts);
        bus.op_start = 1'b1;
        bus.op       = op;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        @(posedge clock); #1;
        bus.op_start = 1'b0;
        lat = 0; starts = 0; kind = -1;
        while (lat < 200) begin
            if (bus.div_start) starts++;
            if (bus.done || bus.div0_exc || bus.timeout_err) begin
                kind = bus.done ? K_DONE : (bus.div0_exc ? K_DIV0 : K_TMO);
                check("pulse_onehot", 32'($countones({bus.done, bus.div0_exc, bus.timeout_err})), 32'd1);
                check("busy_at_pulse", 32'(bus.busy), 32'd0);
                break;
            end
            if (poke && lat == 3) begin
                bus.op_start = 1'b1;
                bus.op       = OP_MTHI;
                bus.rs_val   = ~rs;
            end
            if (poke && lat == 8) bus.op_start = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
    endtask

    // Arithmetic reference for one command; updates the expected HI/LO pair.
    task automatic model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output int kind, output int lat, output int starts);
        longint sa, sb, q, r;
        kind = K_DONE; lat = 0; starts = 0;
        if (op == OP_MTHI) begin
            exp_hi = rs;
        end else if (op == OP_MTLO) begin
            exp_lo = rs;
        end else if (rt == 32'h0) begin
            kind = K_DIV0;
        end else begin
            lat = 35; starts = 1;
            if (op == OP_DIV) begin
                sa = longint'($signed(rs));
                sb = longint'($signed(rt));
            end else begin
                sa = longint'({32'h0, rs});
                sb = longint'({32'h0, rt});
            end
            q = sa / sb;
            r = sa % sb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
        end
    endtask

    vec_t vecs[10];
    int   kind, lat, starts, ekind, elat, estarts;
    logic [1:0]  rop;
    logic [31:0] rrs, rrt;

    initial begin
        n_checks = 0; n_fail = 0; div_hang = 1'b0;
        bus.op_start = 1'b0; bus.op = 2'b00; bus.rs_val = 32'h0; bus.rt_val = 32'h0;
        vecs[0] = '{OP_DIVU, 32'd100,        32'd7,        K_DONE, 35, 1, 32'd2,        32'd14};
        vecs[1] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,        K_DONE, 35, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{OP_DIV,  32'd5,          32'd0,        K_DIV0, 0,  0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_MTHI, 32'hDEAD_BEEF,  32'd0,        K_DONE, 0,  0, 32'hDEAD_BEEF, 32'hFFFF_FFFD};
        vecs[4] = '{OP_MTLO, 32'h1234_5678,  32'd9,        K_DONE, 0,  0, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[5] = '{OP_DIVU, 32'd123,        32'd0,        K_DIV0, 0,  0, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[6] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, K_DONE, 35, 1, 32'h0,        32'h8000_0000};
        vecs[7] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE, K_DONE, 35, 1, 32'd1,        32'hFFFF_FFFD};
        vecs[8] = '{OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD, K_DONE, 35, 1, 32'hFFFF_FFFE, 32'd2};
        vecs[9] = '{OP_DIVU, 32'hFFFF_FFFF,  32'h10,       K_DONE, 35, 1, 32'hF,        32'h0FFF_FFFF};

        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_flags", 32'({bus.busy, bus.done, bus.div0_exc, bus.timeout_err, bus.div_start}), 32'h0);
        check("rst_div_a", bus.div_a, 32'h0);
        check("rst_div_b", bus.div_b, 32'h0);
        #10 reset = 1'b0;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, kind, lat, starts);
            check($sformatf("vec%0d_kind", i), 32'(kind), 32'(vecs[i].kind));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_starts", i), 32'(starts), 32'(vecs[i].starts));
            check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
            exp_hi = vecs[i].hi;
            exp_lo = vecs[i].lo;
        end

        // op_start raised while busy must be ignored.
        run_op(OP_DIVU, 32'd50, 32'd5, 1'b1, kind, lat, starts);
        check("busy_ign_kind", 32'(kind), 32'(K_DONE));
        check("busy_ign_lat", 32'(lat), 32'd35);
        check("busy_ign_hi", bus.hi, 32'd0);
        check("busy_ign_lo", bus.lo, 32'd10);
        exp_hi = 32'd0; exp_lo = 32'd10;

        // Divider that never finishes: watchdog fires after 40 WAIT cycles.
        div_hang = 1'b1;
        run_op(OP_DIVU, 32'd10, 32'd3, 1'b0, kind, lat, starts);
        div_hang = 1'b0;
        check("tmo_kind", 32'(kind), 32'(K_TMO));
        check("tmo_lat", 32'(lat), 32'd41);
        check("tmo_hi", bus.hi, exp_hi);
        check("tmo_lo", bus.lo, exp_lo);

        for (int n = 0; n < 25; n++) begin
            rop = 2'($urandom_range(0, 3));
            rrs = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       rrt = 32'h0;
                1:       rrt = 32'hFFFF_FFFF;
                2:       rrt = 32'($urandom_range(1, 15));
                default: rrt = 32'($urandom);
            endcase
            model(rop, rrs, rrt, ekind, elat, estarts);
            run_op(rop, rrs, rrt, 1'b0, kind, lat, starts);
            check($sformatf("rnd%0d_kind", n), 32'(kind), 32'(ekind));
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(elat));
            check($sformatf("rnd%0d_starts", n), 32'(starts), 32'(estarts));
            check($sformatf("rnd%0d_hi", n), bus.hi, exp_hi);
            check($sformatf("rnd%0d_lo", n), bus.lo, exp_lo);
        end

        // Reset in WAIT cycle 10, then a clean divide.
        run_op(OP_MTHI, 32'h55, 32'h0, 1'b0, kind, lat, starts);
        run_op(OP_MTLO, 32'h66, 32'h0, 1'b0, kind, lat, starts);
        bus.op_start = 1'b1; bus.op = OP_DIVU; bus.rs_val = 32'd1000; bus.rt_val = 32'd7;
        @(posedge clock); #1;
        bus.op_start = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        check("mid_busy", 32'(bus.busy), 32'd1);
        check("mid_hi_held", bus.hi, 32'h55);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_hi", bus.hi, 32'h0);
        check("mid_rst_lo", bus.lo, 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_start", 32'(bus.div_start), 32'd0);
        @(posedge clock); #3;
        reset = 1'b0;
        @(posedge clock); #1;
        run_op(OP_DIVU, 32'd9, 32'd3, 1'b0, kind, lat, starts);
        check("post_rst_kind", 32'(kind), 32'(K_DONE));
        check("post_rst_lat", 32'(lat), 32'd35);
        check("post_rst_lo", bus.lo, 32'd3);
        check("post_rst_hi", bus.hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
